// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the MEM-stage LSU (master) and data memory (slave).
`timescale 1ns/1ps
interface mem_lsu_if;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic        dm_req_write;
  logic [31:0] dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_rdata;
  logic        dm_resp_err;

  modport master (
    output dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    input  dm_req_ready, dm_resp_valid, dm_resp_rdata, dm_resp_err
  );

  modport slave (
    input  dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    output dm_req_ready, dm_resp_valid, dm_resp_rdata, dm_resp_err
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: runs the data-memory handshake, formats store lanes and load
// results, and stalls the pipeline while an access is outstanding.
`timescale 1ns/1ps
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_stall_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       alu_out_i,
  input  logic [31:0]       rs2_data_i,
  mem_lsu_if.master         dm,
  output logic              dm_stall_o,
  output logic [31:0]       load_data_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;

  logic        access, misalign, start, timeout;
  logic [31:0] wdata_fmt, ld_fmt;
  logic [3:0]  wstrb_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign access   = mem_read_i | mem_write_i;
  // funct3[1:0]: 00 byte, 01 half, 1x word (undefined encodings fall into word)
  assign misalign = ((funct3_i[1:0] == 2'b01) && alu_out_i[0]) ||
                    (funct3_i[1] && (alu_out_i[1:0] != 2'b00));
  assign start    = (state_q == StIdle) && access && !misalign;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdata_fmt = rs2_data_i;
    wstrb_fmt = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_fmt = {4{rs2_data_i[7:0]}};
        wstrb_fmt = 4'b0001 << alu_out_i[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{rs2_data_i[15:0]}};
        wstrb_fmt = 4'b0011 << alu_out_i[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_half = off_q[1] ? dm.dm_resp_rdata[31:16] : dm.dm_resp_rdata[15:0];
    case (off_q)
      2'd0:    ld_byte = dm.dm_resp_rdata[7:0];
      2'd1:    ld_byte = dm.dm_resp_rdata[15:8];
      2'd2:    ld_byte = dm.dm_resp_rdata[23:16];
      default: ld_byte = dm.dm_resp_rdata[31:24];
    endcase
    case (funct3_q[1:0])
      2'b00:   ld_fmt = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ld_fmt = dm.dm_resp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (dm.dm_req_ready) state_d = StWait;
      StWait:  if (dm.dm_resp_valid || timeout) state_d = StDone;
      StDone:  if (!im_stall_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    if (start) begin
      addr_d   = {alu_out_i[31:2], 2'b00};
      write_d  = mem_write_i;
      wdata_d  = wdata_fmt;
      wstrb_d  = mem_write_i ? wstrb_fmt : 4'b0000;
      funct3_d = funct3_i;
      off_d    = alu_out_i[1:0];
    end
    if ((state_q == StReq) && dm.dm_req_ready) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A response beats a coincident timeout; stores never touch load_data
      if (dm.dm_resp_valid) begin
        bus_err_d = dm.dm_resp_err;
        if (!write_q) load_data_d = dm.dm_resp_err ? 32'h0 : ld_fmt;
      end else if (timeout) begin
        bus_err_d = 1'b1;
        if (!write_q) load_data_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    dm.dm_req_valid = (state_q == StReq);
    dm.dm_req_write = write_q;
    dm.dm_req_addr  = addr_q;
    dm.dm_req_wdata = wdata_q;
    dm.dm_req_wstrb = wstrb_q;
    dm_stall_o      = start || (state_q == StReq) || (state_q == StWait);
    misaligned_o    = (state_q == StIdle) && access && misalign;
    bus_err_o       = bus_err_q;
    load_data_o     = load_data_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a cycle-driven memory responder.
`timescale 1ns/1ps
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        im_stall, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, rs2_data;
  logic        dm_stall, misaligned, bus_err;
  logic [31:0] load_data;

  int n_pass   = 0;
  int n_checks = 0;

  // Observations from the most recent run_access
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_wstrb;
  logic        o_write, o_unstable;
  int          o_stalls, o_accepts, o_berr, o_reissue;

  mem_lsu_if bus();

  mem_lsu #(.TIMEOUT_CYCLES(256), .CNT_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .im_stall_i   (im_stall),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .alu_out_i    (alu_out),
    .rs2_data_i   (rs2_data),
    .dm           (bus.master),
    .dm_stall_o   (dm_stall),
    .load_data_o  (load_data),
    .misaligned_o (misaligned),
    .bus_err_o    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.dm_req_ready  = 1'b0;
    bus.dm_resp_valid = 1'b0;
    bus.dm_resp_rdata = 32'h0;
    bus.dm_resp_err   = 1'b0;
  endtask

  // Drives one access to completion; resp_lat < 0 means memory never answers.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input logic err,
                            input int ready_lat, input int resp_lat, input int im_hold);
    int vcnt, wcnt;
    bit accepted, in_wait, done, first;
    vcnt = 0; wcnt = 0; accepted = 0; done = 0; first = 1;
    o_stalls = 0; o_accepts = 0; o_berr = 0; o_reissue = 0; o_unstable = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; alu_out = addr; rs2_data = data;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      in_wait = accepted;
      bus.dm_req_ready  = bus.dm_req_valid && (vcnt >= ready_lat);
      bus.dm_resp_valid = in_wait && (resp_lat >= 0) && (wcnt == resp_lat);
      bus.dm_resp_rdata = bus.dm_resp_valid ? rdata : 32'h0;
      bus.dm_resp_err   = bus.dm_resp_valid && err;
      #1;
      if (bus_err) o_berr++;
      if (dm_stall) o_stalls++;
      if (bus.dm_req_valid) begin
        if (!first && ({o_addr, o_wdata, o_wstrb, o_write} !==
            {bus.dm_req_addr, bus.dm_req_wdata, bus.dm_req_wstrb, bus.dm_req_write}))
          o_unstable = 1;
        o_addr = bus.dm_req_addr; o_wdata = bus.dm_req_wdata;
        o_wstrb = bus.dm_req_wstrb; o_write = bus.dm_req_write;
        first = 0;
        vcnt++;
        if (bus.dm_req_ready) o_accepts++;
      end
      if (o_stalls > 0 && !dm_stall) begin
        done = 1;
      end else begin
        if (bus.dm_req_valid && bus.dm_req_ready) accepted = 1;
        if (in_wait) wcnt++;
        step();
      end
    end
    clear_bus();
    if (!done) begin
      n_checks++;
      $display("FAIL access_bound: no completion within 1000 cycles (stalls=%0d)", o_stalls);
    end
    o_ld = load_data;
    for (int k = 0; k < im_hold; k++) begin
      im_stall = 1'b1;
      step();
      if (bus.dm_req_valid || dm_stall) o_reissue++;
      if (bus_err) o_berr++;
    end
    im_stall = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    step();
    if (bus.dm_req_valid || dm_stall) o_reissue++;
    if (bus_err) o_berr++;
  endtask

  task automatic test_reset();
    rst = 1'b1; im_stall = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_out = 0; rs2_data = 0;
    clear_bus();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    n_checks++;
    if ({bus.dm_req_valid, bus.dm_req_write, dm_stall, misaligned, bus_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.dm_req_valid, bus.dm_req_write, dm_stall, misaligned, bus_err});
    else n_pass++;
    n_checks++;
    if ({bus.dm_req_addr, bus.dm_req_wdata, bus.dm_req_wstrb, load_data} !== 100'h0)
      $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b load_data=%h required all 0",
               bus.dm_req_addr, bus.dm_req_wdata, bus.dm_req_wstrb, load_data);
    else n_pass++;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 0);
    n_checks++;
    if (o_addr !== 32'h100) $display("FAIL lw_addr: got %h required 00000100", o_addr);
    else n_pass++;
    n_checks++;
    if ({o_write, o_wstrb} !== 5'b0) $display("FAIL lw_wstrb: got %b required 00000",
                                              {o_write, o_wstrb});
    else n_pass++;
    n_checks++;
    if (o_ld !== 32'hDEADBEEF) $display("FAIL lw_data: got %h required deadbeef", o_ld);
    else n_pass++;
    n_checks++;
    if (o_stalls !== 4) $display("FAIL lw_stall_cycles: got %0d required 4", o_stalls);
    else n_pass++;
    n_checks++;
    if (o_accepts !== 1 || o_unstable !== 1'b0 || o_berr !== 0 || o_reissue !== 0)
      $display("FAIL lw_handshake: accepts=%0d unstable=%b berr=%0d reissue=%0d required 1 0 0 0",
               o_accepts, o_unstable, o_berr, o_reissue);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b1, 1'b0, f3s[i], ads[i], 32'h0, 32'h80FF_0000, 1'b0, 0, 0, 0);
      n_checks++;
      if (o_ld !== exp[i] || o_stalls !== 3 || o_addr !== 32'h100)
        $display("FAIL load_ext[%0d]: data=%h stalls=%0d addr=%h required %h 3 00000100",
                 i, o_ld, o_stalls, o_addr, exp[i]);
      else n_pass++;
    end
    run_access(1'b1, 1'b0, 3'b111, 32'h100, 32'h0, 32'h8000_0001, 1'b0, 0, 0, 0);
    n_checks++;
    if (o_ld !== 32'h80000001) $display("FAIL load_undef_f3: got %h required 80000001", o_ld);
    else n_pass++;
  endtask

  task automatic test_store();
    logic        rds [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ads [3] = '{32'h202, 32'h202, 32'h204};
    logic [31:0] exw [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    logic [3:0]  exs [3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] exa [3] = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      run_access(rds[i], 1'b1, f3s[i], ads[i], 32'h12345678, 32'hAAAAAAAA, 1'b0, 0, 0, 0);
      n_checks++;
      if ({o_write, o_wstrb, o_wdata, o_addr} !== {1'b1, exs[i], exw[i], exa[i]})
        $display("FAIL store[%0d]: write=%b wstrb=%b wdata=%h addr=%h required 1 %b %h %h",
                 i, o_write, o_wstrb, o_wdata, o_addr, exs[i], exw[i], exa[i]);
      else n_pass++;
      n_checks++;
      if (o_ld !== 32'h80000001)
        $display("FAIL store_keeps_load[%0d]: got %h required 80000001", i, o_ld);
      else n_pass++;
    end
  endtask

  task automatic test_misaligned();
    int bad;
    bad = 0;
    mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h101;
    #1;
    n_checks++;
    if ({misaligned, dm_stall, bus.dm_req_valid} !== 3'b100)
      $display("FAIL misaligned_pulse: got %b required 100",
               {misaligned, dm_stall, bus.dm_req_valid});
    else n_pass++;
    step();
    mem_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (misaligned || dm_stall || bus.dm_req_valid) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) $display("FAIL misaligned_after: got %0d busy cycles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 0, -1, 0);
    n_checks++;
    if (o_berr !== 1 || o_ld !== 32'h0 || o_stalls !== 258)
      $display("FAIL timeout: berr=%0d load=%h stalls=%0d required 1 00000000 258",
               o_berr, o_ld, o_stalls);
    else n_pass++;
  endtask

  task automatic test_bus_error();
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, 1'b0, 0, 0, 0);
    n_checks++;
    if (o_ld !== 32'h11223344) $display("FAIL err_preload: got %h required 11223344", o_ld);
    else n_pass++;
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b1, 0, 1, 0);
    n_checks++;
    if (o_berr !== 1 || o_ld !== 32'h0 || o_stalls !== 4)
      $display("FAIL resp_err: berr=%0d load=%h stalls=%0d required 1 00000000 4",
               o_berr, o_ld, o_stalls);
    else n_pass++;
  endtask

  task automatic test_im_stall_hold();
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 1'b0, 0, 0, 3);
    n_checks++;
    if (o_accepts !== 1 || o_reissue !== 0 || o_ld !== 32'h0BADF00D)
      $display("FAIL im_stall_hold: accepts=%0d reissue=%0d load=%h required 1 0 0badf00d",
               o_accepts, o_reissue, o_ld);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    // Reset while the request is on the bus
    mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h500;
    step();
    n_checks++;
    if (bus.dm_req_valid !== 1'b1) $display("FAIL rst_req_setup: valid=%b required 1",
                                            bus.dm_req_valid);
    else n_pass++;
    mem_read = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.dm_req_valid, dm_stall} !== 2'b00)
      $display("FAIL rst_in_req: valid/stall=%b required 00", {bus.dm_req_valid, dm_stall});
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    // Reset while waiting for the response, then a stale response arrives
    mem_read = 1'b1; alu_out = 32'h600;
    step();
    bus.dm_req_ready = 1'b1;
    step();
    bus.dm_req_ready = 1'b0;
    mem_read = 1'b0;
    #1;
    n_checks++;
    if ({bus.dm_req_valid, dm_stall} !== 2'b01)
      $display("FAIL rst_wait_setup: valid/stall=%b required 01", {bus.dm_req_valid, dm_stall});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.dm_req_valid, dm_stall, load_data} !== 34'h0)
      $display("FAIL rst_in_wait: valid=%b stall=%b load=%h required 0 0 00000000",
               bus.dm_req_valid, dm_stall, load_data);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    bus.dm_resp_valid = 1'b1; bus.dm_resp_rdata = 32'hCAFEF00D;
    step();
    clear_bus();
    n_checks++;
    if ({bus.dm_req_valid, dm_stall, bus_err, load_data} !== 35'h0)
      $display("FAIL late_resp_ignored: valid=%b stall=%b err=%b load=%h required 0 0 0 0",
               bus.dm_req_valid, dm_stall, bus_err, load_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_im_stall_hold();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
